// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Imported by the interface, the arbiter and its bench.
package rr_arbiter4_pkg;

   localparam int NUM_REQ          = 4;
   localparam int ID_W             = 2;
   localparam int DEFAULT_MAX_HOLD = 16;
   localparam int DEFAULT_HOLD_W   = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// Handshake protocol:
// - Requester i holds req[i] high for as long as it wants the resource.
// - A grant is live while grant_valid=1. It names its owner with grant_id, and
//   grant carries the same owner as a one-hot vector.
// - The owner ends the grant in either of two ways: pulse done for one cycle,
//   or drop its own req bit.
// - preempt pulses for one cycle when the arbiter ends a grant on its own
//   because the hold limit was reached.
interface rr_arbiter4_if;
   import rr_arbiter4_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               done;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [ID_W-1:0]    grant_id;
   logic               preempt;

   modport master (
      output req, done,
      input  grant, grant_valid, grant_id, preempt
   );

   modport slave (
      input  req, done,
      output grant, grant_valid, grant_id, preempt
   );

endinterface

// File: rtl/rr_arbiter4_dec2to4_en.sv
// 2-to-4 decoder with enable.
// Produces the one-hot grant vector from grant_id and grant_valid.
module dec2to4_en (
   input  logic [1:0] sel_i,
   input  logic       en_i,
   output logic [3:0] dec_o
);

   always_comb begin
      dec_o = 4'b0000;
      if (en_i) dec_o[sel_i] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with an optional hold-time limit.
// Every grant is followed by at least one idle cycle before the next grant.
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
   parameter int HOLD_W   = DEFAULT_HOLD_W
) (
   input  logic                clk,
   input  logic                rst,
   rr_arbiter4_if.slave        bus,
   output arb_state_e          dbg_state_o,
   output logic [ID_W-1:0]     dbg_ptr_o,
   output logic [HOLD_W-1:0]   dbg_hold_o
);

   localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              valid_q, valid_d;
   logic              preempt_q, preempt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic              any_req;
   logic              timeout;
   logic              withdraw;
   logic              release_now;
   logic [ID_W-1:0]   winner;

   // Rotate so the pointer sits at bit 0, take the lowest set bit, then rotate back.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0] p);
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      logic [ID_W-1:0]      off;
      dbl = {r, r} >> p;
      rot = dbl[NUM_REQ-1:0];
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = ID_W'(i);
      end
      return p + off;
   endfunction

   assign any_req     = |bus.req;
   assign winner      = rr_pick(bus.req, ptr_q);
   assign timeout     = TIMEOUT_EN && (hold_q == HOLD_LAST);
   assign withdraw    = !bus.req[id_q];
   assign release_now = bus.done || withdraw || timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
         hold_q    <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = BUSY;
         BUSY:    if (release_now) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d     = ptr_q;
      id_d      = id_q;
      valid_d   = valid_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               id_d    = winner;
               valid_d = 1'b1;
               hold_d  = '0;
            end
         end
         BUSY: begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
            if (release_now) begin
               valid_d   = 1'b0;
               ptr_d     = id_q + 1'b1;
               // Only a pure timeout counts as a preemption.
               preempt_d = timeout && !bus.done && !withdraw;
            end
         end
         default: ;
      endcase
   end

   assign bus.grant_valid = valid_q;
   assign bus.grant_id    = id_q;
   assign bus.preempt     = preempt_q;

   dec2to4_en u_dec (
      .sel_i (id_q),
      .en_i  (valid_q),
      .dec_o (bus.grant)
   );

   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;
   assign dbg_hold_o  = hold_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4. Three instances share the same stimulus and use hold
// limits of 4, 0 and 16; each is compared against a round-robin model.
module tb_rr_arbiter4;
   import rr_arbiter4_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_r;
   logic       done_r;

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   rr_arbiter4_if if4 ();
   rr_arbiter4_if if0 ();
   rr_arbiter4_if if16 ();

   assign if4.req   = req_r;
   assign if4.done  = done_r;
   assign if0.req   = req_r;
   assign if0.done  = done_r;
   assign if16.req  = req_r;
   assign if16.done = done_r;

   arb_state_e st_a[3];
   logic [1:0] ptr_a[3];
   logic [7:0] hold_a[3];

   rr_arbiter4 #(.MAX_HOLD(4),  .HOLD_W(8)) u_d4 (
      .clk(clk), .rst(rst), .bus(if4),
      .dbg_state_o(st_a[0]), .dbg_ptr_o(ptr_a[0]), .dbg_hold_o(hold_a[0]));
   rr_arbiter4 #(.MAX_HOLD(0),  .HOLD_W(8)) u_d0 (
      .clk(clk), .rst(rst), .bus(if0),
      .dbg_state_o(st_a[1]), .dbg_ptr_o(ptr_a[1]), .dbg_hold_o(hold_a[1]));
   rr_arbiter4 #(.MAX_HOLD(16), .HOLD_W(8)) u_d16 (
      .clk(clk), .rst(rst), .bus(if16),
      .dbg_state_o(st_a[2]), .dbg_ptr_o(ptr_a[2]), .dbg_hold_o(hold_a[2]));

   logic [3:0] g_a[3];
   logic       gv_a[3];
   logic [1:0] gid_a[3];
   logic       pre_a[3];

   assign g_a[0] = if4.grant;   assign gv_a[0] = if4.grant_valid;
   assign g_a[1] = if0.grant;   assign gv_a[1] = if0.grant_valid;
   assign g_a[2] = if16.grant;  assign gv_a[2] = if16.grant_valid;
   assign gid_a[0] = if4.grant_id;  assign pre_a[0] = if4.preempt;
   assign gid_a[1] = if0.grant_id;  assign pre_a[1] = if0.preempt;
   assign gid_a[2] = if16.grant_id; assign pre_a[2] = if16.preempt;

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int mh[3] = '{4, 0, 16};
   bit m_busy[3];
   int m_id[3];
   int m_ptr[3];
   int m_hold[3];
   bit m_pre[3];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_id[k] = 0; m_ptr[k] = 0; m_hold[k] = 0; m_pre[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (!m_busy[k]) begin
               m_pre[k] = 0;
               if (req_r != 4'b0000) begin
                  int w;
                  w = -1;
                  for (int j = 0; j < 4; j++)
                     if (w < 0 && req_r[(m_ptr[k] + j) % 4]) w = (m_ptr[k] + j) % 4;
                  m_id[k] = w; m_busy[k] = 1; m_hold[k] = 0;
               end
            end else begin
               bit to, dn, wd;
               to = (mh[k] != 0) && (m_hold[k] == mh[k] - 1);
               dn = done_r;
               wd = !req_r[m_id[k]];
               m_hold[k] = (m_hold[k] < 255) ? m_hold[k] + 1 : 255;
               if (to || dn || wd) begin
                  m_busy[k] = 0;
                  m_ptr[k]  = (m_id[k] + 1) % 4;
                  m_pre[k]  = to && !dn && !wd;
               end else begin
                  m_pre[k] = 0;
               end
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            chk("grant", k, 32'(g_a[k]), m_busy[k] ? (32'd1 << m_id[k]) : 32'd0);
            chk("grant_valid", k, 32'(gv_a[k]), 32'(m_busy[k]));
            chk("grant_id", k, 32'(gid_a[k]), 32'(m_id[k]));
            chk("preempt", k, 32'(pre_a[k]), 32'(m_pre[k]));
            chk("ptr", k, 32'(ptr_a[k]), 32'(m_ptr[k]));
            chk("state", k, 32'(st_a[k]), 32'(m_busy[k]));
            if (m_busy[k]) chk("hold_cnt", k, 32'(hold_a[k]), 32'(m_hold[k]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_grant(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!if16.grant_valid && n < limit);
      chk("grant_wait", 2, 32'(if16.grant_valid), 32'd1);
   endtask

   logic [3:0] rot_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   bit         tv_exp[7]  = '{1, 1, 1, 1, 0, 1, 1};
   bit         tp_exp[7]  = '{0, 0, 0, 0, 1, 0, 0};

   initial begin
      int n;
      int drops;
      rst = 1'b1; req_r = 4'b0000; done_r = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_grant", 2, 32'(if16.grant), 32'd0);
      chk("rst_valid", 2, 32'(if16.grant_valid), 32'd0);
      chk("rst_id", 2, 32'(if16.grant_id), 32'd0);
      chk("rst_preempt", 2, 32'(if16.preempt), 32'd0);
      rst = 1'b0;

      // Async reset in the middle of a grant to requester 2
      req_r = 4'b0100;
      wait_grant(5);
      chk("pre_rst_grant", 2, 32'(if16.grant), 32'h4);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("async_rst_grant", k, 32'(g_a[k]), 32'd0);
         chk("async_rst_valid", k, 32'(gv_a[k]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      req_r = 4'b1111;

      // Rotation with done pulsed once per grant
      for (int i = 0; i < 5; i++) begin
         wait_grant(5);
         chk("rotation", i, 32'(if16.grant), 32'(rot_exp[i]));
         done_r = 1'b1;
         @(negedge clk);
         done_r = 1'b0;
         chk("turnaround_idle", i, 32'(if16.grant_valid), 32'd0);
      end
      req_r = 4'b0000;
      @(negedge clk);

      // Sparse request: grant id 2, then 0011 wraps past 3 to 0
      req_r = 4'b0100;
      wait_grant(5);
      chk("sparse_first", 2, 32'(if16.grant_id), 32'd2);
      done_r = 1'b1;
      @(negedge clk);
      done_r = 1'b0;
      req_r = 4'b0011;
      chk("ptr_after_2", 2, 32'(ptr_a[2]), 32'd3);
      wait_grant(5);
      chk("sparse_wrap", 2, 32'(if16.grant), 32'h1);
      done_r = 1'b1;
      @(negedge clk);
      done_r = 1'b0;
      req_r = 4'b0000;
      chk("ptr_after_0", 2, 32'(ptr_a[2]), 32'd1);

      // Withdrawal of owner 1 in its third grant cycle
      req_r = 4'b0010;
      wait_grant(5);
      chk("withdraw_owner", 2, 32'(if16.grant_id), 32'd1);
      repeat (2) @(negedge clk);
      chk("withdraw_still", 2, 32'(if16.grant_valid), 32'd1);
      req_r = 4'b0000;
      @(negedge clk);
      chk("withdraw_valid", 2, 32'(if16.grant_valid), 32'd0);
      chk("withdraw_preempt", 2, 32'(if16.preempt), 32'd0);
      chk("withdraw_ptr", 2, 32'(ptr_a[2]), 32'd2);

      // Timeout with a limit of 4 on the first instance
      req_r = 4'b0001;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("timeout_valid", i, 32'(if4.grant_valid), 32'(tv_exp[i]));
         chk("timeout_preempt", i, 32'(if4.preempt), 32'(tp_exp[i]));
      end
      chk("timeout_regrant", 0, 32'(if4.grant), 32'h1);

      // done coinciding with the timeout cycle
      n = 0;
      while (hold_a[0] != 8'd3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reach", 0, 32'(hold_a[0]), 32'd3);
      done_r = 1'b1;
      @(negedge clk);
      done_r = 1'b0;
      chk("coincide_valid", 0, 32'(if4.grant_valid), 32'd0);
      chk("coincide_preempt", 0, 32'(if4.preempt), 32'd0);

      // No hold limit: 300-cycle grant, counter saturates
      drops = 0;
      repeat (300) begin
         @(negedge clk);
         if (!if0.grant_valid) drops++;
      end
      chk("nolimit_drops", 1, 32'(drops), 32'd0);
      chk("nolimit_sat", 1, 32'(hold_a[1]), 32'd255);
      req_r = 4'b0000;
      repeat (2) @(negedge clk);

      // Random traffic: short grants, then long grants that reach the limits
      for (int i = 0; i < 3000; i++) begin
         if (i < 1500) begin
            if ($urandom_range(0, 3) == 0) req_r = 4'($urandom_range(0, 15));
            done_r = ($urandom_range(0, 5) == 0);
         end else begin
            if ($urandom_range(0, 24) == 0) req_r = 4'($urandom_range(0, 15));
            done_r = ($urandom_range(0, 39) == 0);
         end
         @(negedge clk);
      end
      req_r = 4'b0000; done_r = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
